usb_tx_line_driver: RTL and testbench
=====================================

USB_TX_LINE_DRIVER -- requirements
Module: usb_tx_line_driver

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 4, meaning clk cycles per USB bit time (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tx_start  input  1  request to begin a packet; sampled only in IDLE.
REQ-005 SHALL have port tx_data  input  8  payload byte, sent LSB first.
REQ-006 SHALL have port tx_last  input  1  qualifies tx_data as final byte of packet.
REQ-007 SHALL have port tx_valid  input  1  tx_data/tx_last valid.
REQ-008 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-009 SHALL have ports dp and dm  output  1 each  registered D+/D- line levels.
REQ-010 SHALL have port oe  output  1  registered pad output enable.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port tx_err  output  1  one-cycle pulse on underrun abort.

Function
REQ-013 SHALL implement states IDLE, SYNC, DATA, EOP.
REQ-014 SHALL generate a bit tick every CLK_PER_BIT cycles from a counter cleared when leaving IDLE.
REQ-015 SHALL, on tx_start=1 in IDLE, enter SYNC; next cycle oe=1 and the line carries the first SYNC bit.
REQ-016 SHALL ignore tx_start outside IDLE.
REQ-017 SHALL send SYNC as raw bits 0,0,0,0,0,0,0,1 (line K J K J K J K K).
REQ-018 SHALL NRZI-encode: raw 0 toggles line state, raw 1 holds; J = dp1/dm0, K = dp0/dm1.
REQ-019 SHALL count consecutive raw 1s, starting with SYNC; after the sixth, SHALL insert one stuff bit (toggle) that consumes no data bit, then clear the count.
REQ-020 SHALL clear the ones count on any emitted 0, including stuff bits.
REQ-021 SHALL hold one byte (data plus last flag) in a holding register; tx_ready = holding empty AND state in {SYNC, DATA} AND no last-flagged byte yet accepted in this packet.
REQ-022 SHALL transfer a byte when tx_valid and tx_ready are both high at a rising edge.
REQ-023 SHALL, at the tick ending the final bit of the current byte (SYNC or data): if holding full, load it into the shift register and enter or stay in DATA with no gap.
REQ-024 SHALL, at that tick, enter EOP if the current byte was last-flagged.
REQ-025 SHALL, at that tick, treat holding empty with no last byte as underrun: enter EOP and pulse tx_err for one cycle.
REQ-026 SHALL emit any pending stuff bit (ones count = 6) after the final data bit before entering EOP.
REQ-027 SHALL drive EOP as 2 bit times SE0 (dp0/dm0) then 1 bit time J, with oe=1 throughout.
REQ-028 SHALL return to IDLE after EOP, with oe=0 and dp=1/dm=0 on the first IDLE cycle.
REQ-029 SHALL ignore tx_valid in IDLE and EOP; tx_ready SHALL be 0 there.

Reset
REQ-030 SHALL, while rst_n=0 (asynchronous, including mid-packet), force state IDLE, oe=0, dp=1, dm=0, tx_ready=0, busy=0, tx_err=0, holding empty, and all counters 0.
REQ-031 SHALL, after rst_n deasserts, act on tx_start no earlier than the first rising edge.

Verification (CLK_PER_BIT=4)
REQ-032 Reset/idle: rst_n low then high, no stimulus -> dp=1, dm=0, oe=0, tx_ready=0, busy=0 indefinitely.
REQ-033 One byte 0x00, tx_last=1 -> line K J K J K J K K, J K J K J K J K, SE0 SE0 J; oe high for exactly 76 cycles; one tx_ready handshake.
REQ-034 One byte 0xFF, tx_last=1 -> after SYNC: K x5, stuff J, J x3, SE0 SE0 J; 20 bit times (80 cycles) with oe high.
REQ-035 Three bytes 0x3C, 0xA5, 0x81 (last on 0x81), tx_valid always high -> 3 handshakes, no gap bits, NRZI matches golden model, tx_err never asserted.
REQ-036 Byte 0x55 with tx_last=0, then tx_valid held low -> EOP starts at end of 0x55's 8th bit; tx_err pulses 1 cycle; busy falls after EOP.
REQ-037 Mid-packet: tx_start pulsed during DATA -> ignored; then rst_n low during DATA -> outputs go to reset values with no clock edge; next tx_start sends a clean packet.

Source files
------------

// File: rtl/usb_tx_line_driver_if.sv
// Byte-stream and USB line signals of the full-speed transmit line driver.
// master = byte source / pad consumer, slave = the line driver itself.
interface usb_tx_line_driver_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       dp;
    logic       dm;
    logic       oe;
    logic       busy;
    logic       tx_err;

    modport master (
        output tx_start, tx_data, tx_last, tx_valid,
        input  tx_ready, dp, dm, oe, busy, tx_err
    );

    modport slave (
        input  tx_start, tx_data, tx_last, tx_valid,
        output tx_ready, dp, dm, oe, busy, tx_err
    );
endinterface

// File: rtl/usb_tx_line_driver.sv
// USB transmit line driver: SYNC, NRZI-encoded LSB-first payload with bit
// stuffing, then SE0/SE0/J end of packet, fed through a one-byte holding register.
module usb_tx_line_driver #(
    parameter int unsigned CLK_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    usb_tx_line_driver_if.slave  bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } state_t;

    localparam logic [7:0] TICK_AT      = 8'(CLK_PER_BIT - 1);
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    state_t     state_q, state_n;
    logic [7:0] cnt_q, cnt_n;
    logic [7:0] shift_q, shift_n;
    logic [2:0] bit_idx_q, bit_idx_n;
    logic [2:0] ones_q, ones_n;
    logic       cur_last_q, cur_last_n;
    logic [7:0] hold_data_q, hold_data_n;
    logic       hold_last_q, hold_last_n;
    logic       hold_full_q, hold_full_n;
    logic       last_acc_q, last_acc_n;
    logic [1:0] eop_cnt_q, eop_cnt_n;
    logic       dp_q, dp_n;
    logic       dm_q, dm_n;
    logic       oe_q, oe_n;
    logic       err_q, err_n;

    logic       tick;
    logic       ready;
    logic       accept;
    logic       emit_en;
    logic       emit_bit;

    // Handshake: a byte (tx_data + tx_last) moves into the holding register on
    // any rising edge where tx_valid && tx_ready; tx_ready depends on registers only.
    assign ready  = !hold_full_q && (state_q == SYNC || state_q == DATA) && !last_acc_q;
    assign accept = bus.tx_valid && ready;
    assign tick   = (cnt_q == TICK_AT);

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        shift_n     = shift_q;
        bit_idx_n   = bit_idx_q;
        ones_n      = ones_q;
        cur_last_n  = cur_last_q;
        hold_data_n = hold_data_q;
        hold_last_n = hold_last_q;
        hold_full_n = hold_full_q;
        last_acc_n  = last_acc_q;
        eop_cnt_n   = eop_cnt_q;
        dp_n        = dp_q;
        dm_n        = dm_q;
        oe_n        = oe_q;
        err_n       = 1'b0;
        emit_en     = 1'b0;
        emit_bit    = 1'b0;

        if (accept) begin
            hold_data_n = bus.tx_data;
            hold_last_n = bus.tx_last;
            hold_full_n = 1'b1;
            if (bus.tx_last) begin
                last_acc_n = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                dp_n  = 1'b1;
                dm_n  = 1'b0;
                oe_n  = 1'b0;
                if (bus.tx_start) begin
                    state_n     = SYNC;
                    shift_n     = SYNC_PATTERN;
                    bit_idx_n   = '0;
                    ones_n      = '0;
                    cur_last_n  = 1'b0;
                    hold_full_n = 1'b0;
                    last_acc_n  = 1'b0;
                    eop_cnt_n   = '0;
                    oe_n        = 1'b1;
                    // First SYNC bit is a raw 0: the idle J toggles to K.
                    dp_n        = 1'b0;
                    dm_n        = 1'b1;
                end
            end

            SYNC, DATA: begin
                cnt_n = tick ? 8'd0 : cnt_q + 8'd1;
                if (tick) begin
                    if (ones_q == 3'd6) begin
                        // Stuff bit: a forced transition that consumes no data bit.
                        dp_n   = ~dp_q;
                        dm_n   = ~dm_q;
                        ones_n = '0;
                    end else if (bit_idx_q != 3'd7) begin
                        shift_n   = shift_q >> 1;
                        bit_idx_n = bit_idx_q + 3'd1;
                        emit_en   = 1'b1;
                        emit_bit  = shift_q[1];
                    end else if (cur_last_q) begin
                        state_n   = EOP;
                        eop_cnt_n = '0;
                        dp_n      = 1'b0;
                        dm_n      = 1'b0;
                    end else if (hold_full_q) begin
                        state_n     = DATA;
                        shift_n     = hold_data_q;
                        bit_idx_n   = '0;
                        cur_last_n  = hold_last_q;
                        hold_full_n = 1'b0;
                        emit_en     = 1'b1;
                        emit_bit    = hold_data_q[0];
                    end else begin
                        // Underrun: nothing to send and no final byte seen.
                        state_n   = EOP;
                        eop_cnt_n = '0;
                        dp_n      = 1'b0;
                        dm_n      = 1'b0;
                        err_n     = 1'b1;
                    end
                end
            end

            EOP: begin
                cnt_n = tick ? 8'd0 : cnt_q + 8'd1;
                if (tick) begin
                    case (eop_cnt_q)
                        2'd0: begin
                            eop_cnt_n = 2'd1;
                        end
                        2'd1: begin
                            eop_cnt_n = 2'd2;
                            dp_n      = 1'b1;
                            dm_n      = 1'b0;
                        end
                        default: begin
                            state_n   = IDLE;
                            eop_cnt_n = '0;
                            cnt_n     = '0;
                            oe_n      = 1'b0;
                            dp_n      = 1'b1;
                            dm_n      = 1'b0;
                        end
                    endcase
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // NRZI: raw 0 toggles the line, raw 1 holds it and extends the run of ones.
        if (emit_en) begin
            if (emit_bit) begin
                ones_n = ones_q + 3'd1;
            end else begin
                dp_n   = ~dp_q;
                dm_n   = ~dm_q;
                ones_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            ones_q      <= '0;
            cur_last_q  <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            last_acc_q  <= 1'b0;
            eop_cnt_q   <= '0;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
            oe_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            shift_q     <= shift_n;
            bit_idx_q   <= bit_idx_n;
            ones_q      <= ones_n;
            cur_last_q  <= cur_last_n;
            hold_data_q <= hold_data_n;
            hold_last_q <= hold_last_n;
            hold_full_q <= hold_full_n;
            last_acc_q  <= last_acc_n;
            eop_cnt_q   <= eop_cnt_n;
            dp_q        <= dp_n;
            dm_q        <= dm_n;
            oe_q        <= oe_n;
            err_q       <= err_n;
        end
    end

    assign bus.tx_ready = ready;
    assign bus.dp       = dp_q;
    assign bus.dm       = dm_q;
    assign bus.oe       = oe_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_err   = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_usb_tx_line_driver.sv
// Randomized self-checking bench for usb_tx_line_driver; expected line activity
// is generated per packet from the USB SYNC/NRZI/stuffing/EOP rules.
module tb_usb_tx_line_driver;

    localparam int CPB = 4;
    localparam logic [4:0] IDLE_VEC = 5'b01000;   // {oe, dp, dm, busy, tx_err}

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    usb_tx_line_driver_if bus();

    usb_tx_line_driver #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int handshakes;

    logic [4:0] exp_q[$];
    logic [7:0] pkt_data[16];
    int         pkt_n;
    bit         pkt_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] line_vec();
        return {bus.oe, bus.dp, bus.dm, bus.busy, bus.tx_err};
    endfunction

    // Reference model: one bit time = CPB cycles of {oe, dp, dm, busy, tx_err}.
    function automatic void push_bit(input logic p, input logic m, input logic err_first);
        for (int c = 0; c < CPB; c++) begin
            exp_q.push_back({1'b1, p, m, 1'b1, (err_first && c == 0)});
        end
    endfunction

    function automatic void build_expected();
        bit   raw[$];
        int   ones;
        logic level;
        exp_q.delete();
        for (int i = 0; i < 8; i++) raw.push_back(i == 7);
        for (int i = 0; i < pkt_n; i++) begin
            for (int k = 0; k < 8; k++) raw.push_back(pkt_data[i][k]);
        end
        level = 1'b1;
        ones  = 0;
        foreach (raw[i]) begin
            if (!raw[i]) begin
                level = ~level;
                ones  = 0;
            end else begin
                ones++;
            end
            push_bit(level, ~level, 1'b0);
            if (ones == 6) begin
                level = ~level;
                ones  = 0;
                push_bit(level, ~level, 1'b0);
            end
        end
        push_bit(1'b0, 1'b0, !pkt_last);
        push_bit(1'b0, 1'b0, 1'b0);
        push_bit(1'b1, 1'b0, 1'b0);
    endfunction

    // Driver tasks
    task automatic drive_bytes(input bit use_gaps);
        int wait_cnt;
        for (int i = 0; i < pkt_n; i++) begin
            if (use_gaps) repeat ($urandom_range(0, 6)) @(negedge clk);
            bus.tx_valid = 1'b1;
            bus.tx_data  = pkt_data[i];
            bus.tx_last  = pkt_last && (i == pkt_n - 1);
            wait_cnt = 0;
            while (!bus.tx_ready && wait_cnt < 200) begin
                @(negedge clk);
                wait_cnt++;
            end
            check("ready_seen", bus.tx_ready, 1'b1);
            if (!bus.tx_ready) begin
                bus.tx_valid = 1'b0;
                break;
            end
            @(negedge clk);
            handshakes++;
            bus.tx_valid = 1'b0;
        end
    endtask

    task automatic monitor(output int oe_cycles);
        logic [4:0] e;
        oe_cycles = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("line", line_vec(), e);
            if (bus.oe) oe_cycles++;
            @(negedge clk);
        end
        check("post_eop_idle", line_vec(), IDLE_VEC);
        check("post_eop_ready", bus.tx_ready, 1'b0);
    endtask

    task automatic poke_start();
        repeat ($urandom_range(20, 60)) @(negedge clk);
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge of the first idle cycle.
    task automatic run_packet(input bit use_gaps, input bit poke, output int oe_cycles);
        build_expected();
        handshakes   = 0;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        fork
            drive_bytes(use_gaps);
            monitor(oe_cycles);
            begin
                if (poke) poke_start();
            end
        join
        check("handshakes", handshakes, pkt_n);
    endtask

    int oc;

    initial begin
        rst_n        = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_line", line_vec(), IDLE_VEC);
        check("reset_ready", bus.tx_ready, 1'b0);
        rst_n = 1'b1;

        // Idle with tx_valid asserted must stay quiet.
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("idle_line", line_vec(), IDLE_VEC);
            check("idle_ready", bus.tx_ready, 1'b0);
        end
        bus.tx_valid = 1'b0;
        @(negedge clk);

        pkt_n = 1; pkt_data[0] = 8'h00; pkt_last = 1'b1;
        run_packet(1'b0, 1'b0, oc);
        check("oe_cycles_00", oc, 76);

        repeat (2) @(negedge clk);
        pkt_n = 1; pkt_data[0] = 8'hFF; pkt_last = 1'b1;
        run_packet(1'b0, 1'b0, oc);
        check("oe_cycles_ff", oc, 80);

        repeat (2) @(negedge clk);
        pkt_n = 3; pkt_data[0] = 8'h3C; pkt_data[1] = 8'hA5; pkt_data[2] = 8'h81;
        pkt_last = 1'b1;
        run_packet(1'b0, 1'b0, oc);

        repeat (2) @(negedge clk);
        pkt_n = 1; pkt_data[0] = 8'h55; pkt_last = 1'b0;
        run_packet(1'b0, 1'b0, oc);
        check("oe_cycles_underrun", oc, 76);

        // Stray start during the packet, then asynchronous reset mid-DATA.
        repeat (2) @(negedge clk);
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h12;
        bus.tx_last  = 1'b0;
        repeat (38) @(negedge clk);
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1'b1);
        check("pre_reset_oe", bus.oe, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_line", line_vec(), IDLE_VEC);
        check("async_reset_ready", bus.tx_ready, 1'b0);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_idle", line_vec(), IDLE_VEC);

        pkt_n = 2; pkt_data[0] = 8'hA5; pkt_data[1] = 8'h7E; pkt_last = 1'b1;
        run_packet(1'b0, 1'b0, oc);

        // Randomized packets with source gaps and stray starts.
        for (int p = 0; p < 24; p++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pkt_n = $urandom_range(1, 4);
            for (int i = 0; i < pkt_n; i++) begin
                pkt_data[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            end
            pkt_last = ($urandom_range(0, 4) != 0);
            run_packet(1'b1, 1'b1, oc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
